// File: rtl/matmul_pkg.sv
// Shared definitions for the 3x3 matrix-multiplier front end: element width,
// matrix dimension, counter widths, loader state encoding and flat-bus packing.
package matmul_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N      = 3;
    localparam int unsigned NE     = N * N;
    localparam int unsigned CNT_W  = $clog2(NE);
    localparam int unsigned RC_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned FLAT_W = NE * DATA_W;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // LSB position of element [i][j] inside a row-major flat matrix bus.
    function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
        return (i * N + j) * DATA_W;
    endfunction

endpackage

// File: rtl/matmul_stream_loader_if.sv
// Stream-in / matrix-out signal bundle of the matrix loader.
// master: the environment (word source and matrix consumer); slave: the loader.
interface matmul_stream_loader_if;
    import matmul_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [FLAT_W-1:0] a_flat;
    logic [FLAT_W-1:0] b_flat;
    logic              m_valid;
    logic              m_ready;
    logic              frame_err;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, a_flat, b_flat, m_valid, frame_err
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, a_flat, b_flat, m_valid, frame_err
    );

endinterface

// File: rtl/mat_elem_counter.sv
// Element position counter for one matrix: linear count with terminal flag,
// plus row/column tracked directly so no divider is needed. In column-major
// mode the fast-moving index is the row instead of the column.
module mat_elem_counter
    import matmul_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    input  logic            col_major,
    output logic [RC_W-1:0] row,
    output logic [RC_W-1:0] col,
    output logic            tc
);

    logic [CNT_W-1:0] cnt;
    logic [RC_W-1:0]  minor;
    logic [RC_W-1:0]  major;

    // Advance linear count and the minor/major position; saturates at the last element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            minor <= '0;
            major <= '0;
        end else if (clr) begin
            cnt   <= '0;
            minor <= '0;
            major <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
            if (minor == RC_W'(N - 1)) begin
                minor <= '0;
                major <= major + 1'b1;
            end else begin
                minor <= minor + 1'b1;
            end
        end
    end

    assign tc  = (cnt == CNT_W'(NE - 1));
    assign row = col_major ? minor : major;
    assign col = col_major ? major : minor;

endmodule

// File: rtl/matmul_stream_loader.sv
// Deserialises a word stream (A row-major, then B) into two element banks and
// presents both matrices as flat buses with a valid/ready handshake.
// Optional build macro LOADER_B_COLMAJOR_EN: B words arrive column-major;
// b_flat packing is unchanged either way.
module matmul_stream_loader
    import matmul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    matmul_stream_loader_if.slave bus
);

    state_t            state, state_n;
    logic              s_ready_q, m_valid_q, frame_err_q;
    logic              err_n, cnt_clr, cnt_inc, wr_a, wr_b;
    logic              xfer, col_major, tc;
    logic [RC_W-1:0]   row, col;
    logic [FLAT_W-1:0] a_q, b_q;

    assign xfer = bus.s_valid && s_ready_q;

`ifdef LOADER_B_COLMAJOR_EN
    assign col_major = (state == LOAD_B);
`else
    assign col_major = 1'b0;
`endif

    mat_elem_counter u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .col_major (col_major),
        .row       (row),
        .col       (col),
        .tc        (tc)
    );

    // Next-state, bank write enables and framing error; flush overrides everything.
    always_comb begin
        state_n = state;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        err_n   = 1'b0;
        if (flush) begin
            state_n = LOAD_A;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        if (bus.s_last) begin
                            err_n   = 1'b1;
                            cnt_clr = 1'b1;
                        end else begin
                            wr_a = 1'b1;
                            if (tc) begin
                                state_n = LOAD_B;
                                cnt_clr = 1'b1;
                            end else begin
                                cnt_inc = 1'b1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        if (tc) begin
                            // Pair completes even if s_last is missing; only flag it.
                            wr_b    = 1'b1;
                            state_n = HOLD;
                            cnt_clr = 1'b1;
                            err_n   = !bus.s_last;
                        end else if (bus.s_last) begin
                            err_n   = 1'b1;
                            state_n = LOAD_A;
                            cnt_clr = 1'b1;
                        end else begin
                            wr_b    = 1'b1;
                            cnt_inc = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (m_valid_q && bus.m_ready) begin
                        state_n = LOAD_A;
                    end
                end
                default: begin
                    state_n = LOAD_A;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // State and registered handshake outputs; s_ready stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD_A;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_n;
            s_ready_q   <= (state_n != HOLD);
            m_valid_q   <= (state_n == HOLD);
            frame_err_q <= err_n;
        end
    end

    // Element banks: written only by accepted words, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (wr_a) a_q[elem_lsb(32'(row), 32'(col)) +: DATA_W] <= bus.s_data;
            if (wr_b) b_q[elem_lsb(32'(row), 32'(col)) +: DATA_W] <= bus.s_data;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.a_flat    = a_q;
    assign bus.b_flat    = b_q;

endmodule
